// File: rtl/spike_aer_tx_if.sv
// Bundle of handshake, FIFO and AER signals for the spike AER transmitter.
// The master modport is the transmitter side; the slave modport is its environment.
interface spike_aer_tx_if #(
  parameter int N = 256,
  parameter int M = 8
) ();
  localparam int AW = $clog2(N);

  logic          start_i;
  logic          control_i;
  logic          LIF_busy_i;
  logic          LIF_done_i;
  logic          FIFO_empty_i;
  logic          FIFO_r_en_o;
  logic [M-1:0]  FIFO_r_data_i;
  logic [AW-1:0] AER_ADDR_o;
  logic          AER_REQ_o;
  logic          AER_ACK_i;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [AW:0]   sent_cnt_o;

  modport master (
    input  start_i, control_i, LIF_busy_i, LIF_done_i, FIFO_empty_i,
           FIFO_r_data_i, AER_ACK_i,
    output FIFO_r_en_o, AER_ADDR_o, AER_REQ_o, busy_o, done_o, err_o,
           sent_cnt_o
  );

  modport slave (
    output start_i, control_i, LIF_busy_i, LIF_done_i, FIFO_empty_i,
           FIFO_r_data_i, AER_ACK_i,
    input  FIFO_r_en_o, AER_ADDR_o, AER_REQ_o, busy_o, done_o, err_o,
           sent_cnt_o
  );
endinterface

// File: rtl/spike_aer_tx.sv
// Drains a spike FIFO onto a 4-phase AER link, optionally pacing each event
// on the downstream LIF engine, with a per-phase acknowledge timeout.
module spike_aer_tx #(
  parameter int N           = 256,
  parameter int M           = 8,
  parameter int ACK_TIMEOUT = 1024
) (
  input logic            CLK,
  input logic            RST,
  spike_aer_tx_if.master bus
);
  localparam int AW = $clog2(N);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_MAX    = CW'(N);
  localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, CHECK, POP, LATCH, REQ, REL, WAIT_LIF, DONE
  } state_t;

  state_t        state_reg;
  logic          ack_meta_reg;
  logic          ack_s_reg;
  logic [TW-1:0] timer_reg;
  logic [AW-1:0] addr_reg;
  logic [CW-1:0] cnt_reg;
  logic          req_reg;
  logic          r_en_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          err_reg;

  // AER_ACK_i comes from another timing domain.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ack_meta_reg <= 1'b0;
      ack_s_reg    <= 1'b0;
    end else begin
      ack_meta_reg <= bus.AER_ACK_i;
      ack_s_reg    <= ack_meta_reg;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      timer_reg <= '0;
      addr_reg  <= '0;
      cnt_reg   <= '0;
      req_reg   <= 1'b0;
      r_en_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      r_en_reg <= 1'b0;
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start_i) begin
            state_reg <= CHECK;
            busy_reg  <= 1'b1;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
          end
        end
        CHECK: begin
          if (bus.FIFO_empty_i) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end else if (!bus.LIF_busy_i) begin
            state_reg <= POP;
            r_en_reg  <= 1'b1;
          end
        end
        POP: state_reg <= LATCH;
        LATCH: begin
          addr_reg  <= AW'(bus.FIFO_r_data_i);
          req_reg   <= 1'b1;
          timer_reg <= '0;
          state_reg <= REQ;
        end
        REQ: begin
          if (ack_s_reg) begin
            req_reg   <= 1'b0;
            timer_reg <= '0;
            state_reg <= REL;
          end else if (timer_reg == TIMER_LAST) begin
            req_reg   <= 1'b0;
            err_reg   <= 1'b1;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        REL: begin
          if (!ack_s_reg) begin
            if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + CW'(1);
            state_reg <= bus.control_i ? CHECK : WAIT_LIF;
          end else if (timer_reg == TIMER_LAST) begin
            // Timed-out release leaves the event uncounted.
            err_reg   <= 1'b1;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        WAIT_LIF: begin
          if (bus.LIF_done_i) state_reg <= CHECK;
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.FIFO_r_en_o = r_en_reg;
  assign bus.AER_ADDR_o  = addr_reg;
  assign bus.AER_REQ_o   = req_reg;
  assign bus.busy_o      = busy_reg;
  assign bus.done_o      = done_reg;
  assign bus.err_o       = err_reg;
  assign bus.sent_cnt_o  = cnt_reg;
endmodule

// File: tb/tb_spike_aer_tx.sv
// Bench for spike_aer_tx: a queue-based FIFO, ACK and LIF environment plus a
// scoreboard of the address sequence each drain should emit.
module tb_spike_aer_tx;
  localparam int N  = 256;
  localparam int M  = 8;
  localparam int AW = 8;
  localparam int TO = 16;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  spike_aer_tx_if #(.N(N), .M(M)) bus ();
  spike_aer_tx #(.N(N), .M(M), .ACK_TIMEOUT(TO)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  int fifo_q[$];
  int late_q[$];
  int obs_addr[$];
  int ack_delay;
  bit ack_never;
  int busy_pct;
  int lif_min, lif_max;
  bit spur_start, spur_lif;
  logic [7:0] req_hist;
  int lif_timer;
  bit lif_pending;
  int cnt_prev;
  int n_done, n_pop, n_req_cycles, n_req_pulses, n_pop_busy, n_addr_unstable, n_pop_early;

  // One clock of environment: observe outputs after the edge, then drive inputs.
  task automatic step();
    logic          req_prev, busy_in;
    logic [AW-1:0] addr_prev;
    req_prev  = bus.AER_REQ_o;
    busy_in   = bus.LIF_busy_i;
    addr_prev = bus.AER_ADDR_o;
    @(posedge CLK);
    #1;
    if (bus.FIFO_r_en_o) begin
      n_pop++;
      if (busy_in) n_pop_busy++;
      if (lif_pending) n_pop_early++;
      if (fifo_q.size() > 0) bus.FIFO_r_data_i = 8'(fifo_q.pop_front());
    end
    if (bus.AER_REQ_o) begin
      n_req_cycles++;
      if (!req_prev) begin
        n_req_pulses++;
        obs_addr.push_back(int'(bus.AER_ADDR_o));
        if (late_q.size() > 0) fifo_q.push_back(late_q.pop_front());
      end else if (bus.AER_ADDR_o !== addr_prev) begin
        n_addr_unstable++;
      end
    end
    if (bus.done_o) n_done++;
    if (int'(bus.sent_cnt_o) > cnt_prev && !bus.control_i) begin
      lif_pending = 1'b1;
      lif_timer   = int'($urandom_range(lif_max, lif_min));
    end
    cnt_prev = int'(bus.sent_cnt_o);

    bus.FIFO_empty_i = (fifo_q.size() == 0);
    bus.LIF_done_i   = 1'b0;
    if (lif_timer == 0) begin
      bus.LIF_done_i = 1'b1;
      lif_pending    = 1'b0;
      lif_timer      = -1;
    end else if (lif_timer > 0) begin
      lif_timer--;
    end else if (spur_lif && !lif_pending && $urandom_range(0, 7) == 0) begin
      bus.LIF_done_i = 1'b1;
    end
    bus.LIF_busy_i = (int'($urandom_range(0, 99)) < busy_pct);
    req_hist       = {req_hist[6:0], bus.AER_REQ_o};
    bus.AER_ACK_i  = ack_never ? 1'b0 : req_hist[ack_delay];
    bus.start_i    = spur_start && bus.busy_o && ($urandom_range(0, 3) == 0);
  endtask

  task automatic clear_obs();
    obs_addr.delete();
    n_done = 0; n_pop = 0; n_req_cycles = 0; n_req_pulses = 0;
    n_pop_busy = 0; n_addr_unstable = 0; n_pop_early = 0;
    lif_pending = 1'b0; lif_timer = -1; cnt_prev = 0;
  endtask

  task automatic set_env(input int dly, input bit never, input int bpct,
                         input int lmin, input int lmax, input bit sstart, input bit slif);
    ack_delay = dly; ack_never = never; busy_pct = bpct;
    lif_min = lmin; lif_max = lmax; spur_start = sstart; spur_lif = slif;
  endtask

  task automatic load_fifo(input int vals[$]);
    fifo_q = vals;
    bus.FIFO_empty_i = (fifo_q.size() == 0);
  endtask

  // Pulse start and run until done_o (bounded), plus one cycle back to IDLE.
  task automatic run_drain(input bit ctrl, input int budget, output int done_at);
    clear_obs();
    bus.control_i = ctrl;
    bus.start_i   = 1'b1;
    done_at = -1;
    for (int n = 1; n <= budget && done_at < 0; n++) begin
      step();
      if (bus.done_o) done_at = n;
    end
    step();
  endtask

  task automatic apply_reset();
    bit keep_spur;
    keep_spur  = spur_start;
    spur_start = 1'b0;
    RST = 1'b1;
    req_hist = '0;
    bus.start_i = 1'b0; bus.LIF_done_i = 1'b0; bus.AER_ACK_i = 1'b0;
    step();
    step();
    RST = 1'b0;
    req_hist = '0;
    spur_start = keep_spur;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (bus.AER_REQ_o !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b expected 0", bus.AER_REQ_o); end
    n_cmp++; if (bus.FIFO_r_en_o !== 1'b0) begin n_bad++; $display("FAIL reset_r_en: got %b expected 0", bus.FIFO_r_en_o); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o); end
    n_cmp++; if (bus.done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", bus.done_o); end
    n_cmp++; if (bus.err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", bus.err_o); end
    n_cmp++; if (bus.AER_ADDR_o !== '0) begin n_bad++; $display("FAIL reset_addr: got %0d expected 0", bus.AER_ADDR_o); end
    n_cmp++; if (bus.sent_cnt_o !== '0) begin n_bad++; $display("FAIL reset_cnt: got %0d expected 0", bus.sent_cnt_o); end
    $display("test_reset: outputs checked after reset");
  endtask

  task automatic test_burst_directed();
    int exp_a[$];
    int done_at;
    exp_a = '{3, 17, 255};
    set_env(1, 0, 0, 0, 0, 0, 0);
    load_fifo(exp_a);
    run_drain(1'b1, 500, done_at);
    n_cmp++; if (obs_addr.size() != 3) begin n_bad++; $display("FAIL burst_pulses: got %0d expected 3", obs_addr.size()); end
    for (int i = 0; i < 3 && i < obs_addr.size(); i++) begin
      n_cmp++;
      if (obs_addr[i] != exp_a[i]) begin n_bad++; $display("FAIL burst_addr[%0d]: got %0d expected %0d", i, obs_addr[i], exp_a[i]); end
    end
    n_cmp++; if (bus.sent_cnt_o !== 9'd3) begin n_bad++; $display("FAIL burst_cnt: got %0d expected 3", bus.sent_cnt_o); end
    n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL burst_done: got %0d pulses expected 1", n_done); end
    n_cmp++; if (bus.err_o !== 1'b0) begin n_bad++; $display("FAIL burst_err: got %b expected 0", bus.err_o); end
    $display("test_burst_directed: %0d events, done at cycle %0d", obs_addr.size(), done_at);
  endtask

  task automatic test_empty_start();
    int none[$];
    int done_at;
    set_env(1, 0, 0, 0, 0, 0, 0);
    load_fifo(none);
    run_drain(1'b1, 50, done_at);
    n_cmp++; if (done_at != 2) begin n_bad++; $display("FAIL empty_done_latency: got %0d expected 2", done_at); end
    n_cmp++; if (n_req_cycles != 0) begin n_bad++; $display("FAIL empty_req: got %0d req cycles expected 0", n_req_cycles); end
    n_cmp++; if (bus.sent_cnt_o !== '0) begin n_bad++; $display("FAIL empty_cnt: got %0d expected 0", bus.sent_cnt_o); end
    n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL empty_done_count: got %0d expected 1", n_done); end
    $display("test_empty_start: done at cycle %0d", done_at);
  endtask

  task automatic test_paced_lif();
    int exp_a[$];
    int done_at;
    exp_a = '{int'($urandom_range(0, 255)), int'($urandom_range(0, 255))};
    set_env(2, 0, 30, 50, 50, 0, 1);
    load_fifo(exp_a);
    run_drain(1'b0, 2000, done_at);
    n_cmp++; if (n_pop != 2) begin n_bad++; $display("FAIL paced_pops: got %0d expected 2", n_pop); end
    n_cmp++; if (n_pop_early != 0) begin n_bad++; $display("FAIL paced_pop_before_lif: got %0d expected 0", n_pop_early); end
    n_cmp++; if (n_pop_busy != 0) begin n_bad++; $display("FAIL paced_pop_while_busy: got %0d expected 0", n_pop_busy); end
    n_cmp++; if (obs_addr.size() != 2) begin n_bad++; $display("FAIL paced_pulses: got %0d expected 2", obs_addr.size()); end
    for (int i = 0; i < 2 && i < obs_addr.size(); i++) begin
      n_cmp++;
      if (obs_addr[i] != exp_a[i]) begin n_bad++; $display("FAIL paced_addr[%0d]: got %0d expected %0d", i, obs_addr[i], exp_a[i]); end
    end
    n_cmp++; if (bus.sent_cnt_o !== 9'd2) begin n_bad++; $display("FAIL paced_cnt: got %0d expected 2", bus.sent_cnt_o); end
    $display("test_paced_lif: done at cycle %0d", done_at);
  endtask

  task automatic test_timeout();
    int one[$];
    int none[$];
    int done_at;
    one = '{int'($urandom_range(0, 255))};
    set_env(1, 1, 0, 0, 0, 0, 0);
    load_fifo(one);
    run_drain(1'b1, 200, done_at);
    n_cmp++; if (n_req_cycles != TO) begin n_bad++; $display("FAIL timeout_req_len: got %0d expected %0d", n_req_cycles, TO); end
    n_cmp++; if (bus.err_o !== 1'b1) begin n_bad++; $display("FAIL timeout_err: got %b expected 1", bus.err_o); end
    n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL timeout_done: got %0d expected 1", n_done); end
    n_cmp++; if (bus.sent_cnt_o !== '0) begin n_bad++; $display("FAIL timeout_cnt: got %0d expected 0", bus.sent_cnt_o); end
    set_env(1, 0, 0, 0, 0, 0, 0);
    load_fifo(none);
    run_drain(1'b1, 50, done_at);
    n_cmp++; if (bus.err_o !== 1'b0) begin n_bad++; $display("FAIL timeout_err_clear: got %b expected 0", bus.err_o); end
    $display("test_timeout: req held %0d cycles", n_req_cycles);
  endtask

  task automatic test_reset_mid();
    int vals[$];
    int exp_a[$];
    int done_at;
    bit seen;
    vals  = '{int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255))};
    exp_a = '{vals[1], vals[2]};
    set_env(1, 1, 0, 0, 0, 0, 0);
    load_fifo(vals);
    clear_obs();
    bus.control_i = 1'b1;
    bus.start_i   = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      step();
      seen = bus.AER_REQ_o;
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL rstmid_req_seen: got 0 expected 1"); end
    RST = 1'b1;
    step();
    n_cmp++; if (bus.AER_REQ_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_req_drop: got %b expected 0", bus.AER_REQ_o); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy_o); end
    RST = 1'b0;
    req_hist = '0;
    set_env(1, 0, 0, 0, 0, 0, 0);
    run_drain(1'b1, 500, done_at);
    n_cmp++; if (obs_addr.size() != 2) begin n_bad++; $display("FAIL rstmid_pulses: got %0d expected 2", obs_addr.size()); end
    for (int i = 0; i < 2 && i < obs_addr.size(); i++) begin
      n_cmp++;
      if (obs_addr[i] != exp_a[i]) begin n_bad++; $display("FAIL rstmid_addr[%0d]: got %0d expected %0d", i, obs_addr[i], exp_a[i]); end
    end
    n_cmp++; if (bus.sent_cnt_o !== 9'd2) begin n_bad++; $display("FAIL rstmid_cnt: got %0d expected 2", bus.sent_cnt_o); end
    $display("test_reset_mid: restart drained %0d events", obs_addr.size());
  endtask

  // Random drains with spurious start pulses, LIF backpressure and late FIFO writes.
  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int vals[$];
      int exp_a[$];
      int done_at;
      bit ctrl;
      int cnt_n;
      cnt_n = int'($urandom_range(1, 6));
      for (int k = 0; k < cnt_n; k++) vals.push_back(int'($urandom_range(0, 255)));
      exp_a = vals;
      late_q.delete();
      if ($urandom_range(0, 1) == 1) begin
        late_q.push_back(int'($urandom_range(0, 255)));
        exp_a.push_back(late_q[0]);
      end
      ctrl = 1'($urandom_range(0, 1));
      set_env(int'($urandom_range(1, 4)), 0, int'($urandom_range(0, 40)), 0, 10, 1, 1);
      load_fifo(vals);
      run_drain(ctrl, 3000, done_at);
      n_cmp++; if (obs_addr.size() != exp_a.size()) begin n_bad++; $display("FAIL rand%0d_pulses: got %0d expected %0d", it, obs_addr.size(), exp_a.size()); end
      for (int i = 0; i < exp_a.size() && i < obs_addr.size(); i++) begin
        n_cmp++;
        if (obs_addr[i] != exp_a[i]) begin n_bad++; $display("FAIL rand%0d_addr[%0d]: got %0d expected %0d", it, i, obs_addr[i], exp_a[i]); end
      end
      n_cmp++; if (int'(bus.sent_cnt_o) != exp_a.size()) begin n_bad++; $display("FAIL rand%0d_cnt: got %0d expected %0d", it, bus.sent_cnt_o, exp_a.size()); end
      n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL rand%0d_done: got %0d expected 1", it, n_done); end
      n_cmp++; if (bus.err_o !== 1'b0) begin n_bad++; $display("FAIL rand%0d_err: got %b expected 0", it, bus.err_o); end
      n_cmp++; if (n_pop_busy != 0) begin n_bad++; $display("FAIL rand%0d_pop_busy: got %0d expected 0", it, n_pop_busy); end
      n_cmp++; if (n_addr_unstable != 0) begin n_bad++; $display("FAIL rand%0d_addr_stable: got %0d changes expected 0", it, n_addr_unstable); end
      n_cmp++; if (n_pop_early != 0) begin n_bad++; $display("FAIL rand%0d_pop_before_lif: got %0d expected 0", it, n_pop_early); end
      $display("test_random %0d: ctrl=%0d events=%0d done at cycle %0d", it, ctrl, exp_a.size(), done_at);
    end
    spur_start = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    bus.start_i = 1'b0; bus.control_i = 1'b1; bus.LIF_busy_i = 1'b0; bus.LIF_done_i = 1'b0;
    bus.FIFO_empty_i = 1'b1; bus.FIFO_r_data_i = '0; bus.AER_ACK_i = 1'b0;
    req_hist = '0;
    set_env(1, 0, 0, 0, 0, 0, 0);
    clear_obs();
    test_reset();
    test_burst_directed();
    test_empty_start();
    test_paced_lif();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
